// File: rtl/rob_pkg.sv
// Shared types and tag/index helpers for the reorder buffer.
// Tag 0 is reserved for "no tag", so entry i is always addressed by tag i+1.
package rob_pkg;

  localparam int ROB_DEPTH  = 16;
  localparam int ROB_TAG_W  = $clog2(ROB_DEPTH + 1);
  localparam int ROB_IDX_W  = $clog2(ROB_DEPTH);
  localparam int ROB_DATA_W = 64;

  localparam logic [ROB_TAG_W-1:0] ROB_TAG_NONE = '0;

  typedef struct packed {
    logic                  busy;
    logic                  done;
    logic [4:0]            dest_reg;
    logic [ROB_DATA_W-1:0] value;
  } rob_entry_t;

  function automatic logic [ROB_IDX_W-1:0] tag_to_idx(input logic [ROB_TAG_W-1:0] tag);
    return ROB_IDX_W'(tag - 1'b1);
  endfunction

  function automatic logic [ROB_TAG_W-1:0] idx_to_tag(input logic [ROB_IDX_W-1:0] idx);
    return ROB_TAG_W'(idx) + 1'b1;
  endfunction

endpackage

// File: rtl/rob_lookup.sv
// Operand lookup for one source tag: no-tag, same-cycle writeback bypass, then stored result.
module rob_lookup
  import rob_pkg::*;
#(
  parameter int TAG_W  = ROB_TAG_W,
  parameter int DATA_W = ROB_DATA_W
) (
  input  logic [TAG_W-1:0]  src_tag,
  input  logic              ent_done,
  input  logic [DATA_W-1:0] ent_value,
  input  logic              exec_wb,
  input  logic [TAG_W-1:0]  exec_tag,
  input  logic [DATA_W-1:0] exec_val,
  input  logic              mem_wb,
  input  logic [TAG_W-1:0]  mem_tag,
  input  logic [DATA_W-1:0] mem_val,
  output logic [DATA_W:0]   src_val
);

  // Mem is checked before exec so a load result wins when both target this tag.
  always_comb begin
    src_val = '0;
    if (src_tag == TAG_W'(ROB_TAG_NONE)) begin
      src_val = {1'b1, {DATA_W{1'b0}}};
    end else if (mem_wb && (mem_tag == src_tag)) begin
      src_val = {1'b1, mem_val};
    end else if (exec_wb && (exec_tag == src_tag)) begin
      src_val = {1'b1, exec_val};
    end else if (ent_done) begin
      src_val = {1'b1, ent_value};
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: tag allocation at decode, exec/mem result capture,
// operand lookup with bypass, and single in-order retirement per cycle.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int ROBsize    = ROB_DEPTH,
  parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  allocValid_i,
  input  logic [4:0]            allocDestReg_i,
  output logic                  allocReady_o,
  output logic [ROBsizeLog-1:0] allocTag_o,
  input  logic [ROBsizeLog-1:0] srcTag1_i,
  input  logic [ROBsizeLog-1:0] srcTag2_i,
  output logic [64:0]           srcVal1_o,
  output logic [64:0]           srcVal2_o,
  input  logic [ROBsizeLog-1:0] execTag_i,
  input  logic [63:0]           execVal_i,
  input  logic                  execMemAccess_i,
  input  logic [ROBsizeLog-1:0] memTag_i,
  input  logic [63:0]           memVal_i,
  input  logic                  commitStall_i,
  output logic [ROBsizeLog-1:0] commitTag_o,
  output logic [64:0]           commitVal_o,
  output logic [4:0]            commitDestReg_o,
  output logic [ROBsizeLog-1:0] count_o
);

  localparam int IDX_W = $clog2(ROBsize);
  localparam logic [ROBsizeLog-1:0] SIZE_TAG = ROBsizeLog'(ROBsize);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(ROBsize - 1);

  logic [ROBsize-1:0]    busy_q;
  logic [ROBsize-1:0]    done_q;
  logic [4:0]            dest_q  [ROBsize];
  logic [63:0]           value_q [ROBsize];
  logic [IDX_W-1:0]      head_q;
  logic [IDX_W-1:0]      tail_q;
  logic [ROBsizeLog-1:0] count_q;

  logic                  alloc_fire;
  logic                  retire;
  logic                  exec_wb;
  logic                  mem_wb;
  logic [IDX_W-1:0]      exec_idx;
  logic [IDX_W-1:0]      mem_idx;
  logic [IDX_W-1:0]      src1_idx;
  logic [IDX_W-1:0]      src2_idx;
  logic [ROBsize-1:0]    wb_hit;
  rob_entry_t            head_ent;

  function automatic logic tag_valid(input logic [ROBsizeLog-1:0] tag);
    return (tag != ROBsizeLog'(ROB_TAG_NONE)) && (tag <= SIZE_TAG);
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(input logic [ROBsizeLog-1:0] tag);
    return IDX_W'(tag_to_idx(ROB_TAG_W'(tag)));
  endfunction

  assign exec_idx = to_idx(execTag_i);
  assign mem_idx  = to_idx(memTag_i);
  assign src1_idx = to_idx(srcTag1_i);
  assign src2_idx = to_idx(srcTag2_i);

  // Address-only exec results never complete an entry; writebacks to idle entries are dropped.
  assign exec_wb = tag_valid(execTag_i) && !execMemAccess_i && busy_q[exec_idx];
  assign mem_wb  = tag_valid(memTag_i) && busy_q[mem_idx];

  always_comb begin
    wb_hit = '0;
    for (int i = 0; i < ROBsize; i++) begin
      wb_hit[i] = (exec_wb && (exec_idx == IDX_W'(i))) || (mem_wb && (mem_idx == IDX_W'(i)));
    end
  end

  // Readiness uses only the registered count, so a same-cycle retire never frees a slot early.
  assign allocReady_o = (count_q != SIZE_TAG);
  assign allocTag_o   = ROBsizeLog'(idx_to_tag(ROB_IDX_W'(tail_q)));
  assign alloc_fire   = allocValid_i && allocReady_o;
  assign count_o      = count_q;

  assign head_ent = '{busy:     busy_q[head_q],
                      done:     done_q[head_q],
                      dest_reg: dest_q[head_q],
                      value:    value_q[head_q]};

  assign retire = head_ent.busy && head_ent.done && !commitStall_i;

  always_comb begin
    commitTag_o     = '0;
    commitVal_o     = '0;
    commitDestReg_o = '0;
    if (retire) begin
      commitTag_o     = ROBsizeLog'(idx_to_tag(ROB_IDX_W'(head_q)));
      commitVal_o     = {1'b1, head_ent.value};
      commitDestReg_o = head_ent.dest_reg;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      busy_q  <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < ROBsize; i++) begin
        if (alloc_fire && (tail_q == IDX_W'(i))) begin
          busy_q[i] <= 1'b1;
          done_q[i] <= 1'b0;
        end else if (retire && (head_q == IDX_W'(i))) begin
          busy_q[i] <= 1'b0;
          done_q[i] <= 1'b0;
        end else if (wb_hit[i]) begin
          done_q[i] <= 1'b1;
        end
      end
      if (alloc_fire) begin
        tail_q <= (tail_q == LAST_IDX) ? '0 : tail_q + 1'b1;
      end
      if (retire) begin
        head_q <= (head_q == LAST_IDX) ? '0 : head_q + 1'b1;
      end
      case ({alloc_fire, retire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload needs no reset: it is only observed through busy/done. The mem write is
  // issued last so it overrides an exec write to the same entry.
  always_ff @(posedge clk_i) begin
    if (alloc_fire) begin
      dest_q[tail_q] <= allocDestReg_i;
    end
    if (exec_wb) begin
      value_q[exec_idx] <= execVal_i;
    end
    if (mem_wb) begin
      value_q[mem_idx] <= memVal_i;
    end
  end

  rob_lookup #(.TAG_W(ROBsizeLog), .DATA_W(64)) u_lookup1 (
    .src_tag   (srcTag1_i),
    .ent_done  (tag_valid(srcTag1_i) && done_q[src1_idx]),
    .ent_value (value_q[src1_idx]),
    .exec_wb   (exec_wb),
    .exec_tag  (execTag_i),
    .exec_val  (execVal_i),
    .mem_wb    (mem_wb),
    .mem_tag   (memTag_i),
    .mem_val   (memVal_i),
    .src_val   (srcVal1_o)
  );

  rob_lookup #(.TAG_W(ROBsizeLog), .DATA_W(64)) u_lookup2 (
    .src_tag   (srcTag2_i),
    .ent_done  (tag_valid(srcTag2_i) && done_q[src2_idx]),
    .ent_value (value_q[src2_idx]),
    .exec_wb   (exec_wb),
    .exec_tag  (execTag_i),
    .exec_val  (execVal_i),
    .mem_wb    (mem_wb),
    .mem_tag   (memTag_i),
    .mem_val   (memVal_i),
    .src_val   (srcVal2_o)
  );

endmodule
